loop_sequencer: RTL

Parametrised loop sequencer for the P1 bench infrastructure. On a start request it emits a programmable number of indexed beats (0..N-1, N-1..0, or repeating passes) over a valid/ready stream. It is the synthesisable, handshaked replacement for fixed 32-iteration simulation loops. It sits between a bench or controller issuing `start` and any consumer that accepts one indexed event per handshake.

---
 rtl/loop_sequencer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/loop_sequencer.sv
// Handshaked loop sequencer: emits N indexed beats per pass (up, down or continuous up)
// over a valid/ready stream, with a saturating completed-pass counter.
module loop_sequencer #(
    parameter int IDX_W  = 5,
    parameter int PASS_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [IDX_W:0]    count_in,
    input  logic [1:0]        mode,
    input  logic              abort,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [PASS_W-1:0] pass_cnt
);

    // state | meaning
    // IDLE  | waiting for start; outputs quiet
    // RUN   | presenting beats on the stream
    // DONE  | one-cycle done pulse, then back to IDLE
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [IDX_W:0] N_MAX = {1'b1, {IDX_W{1'b0}}};

    state_t           state;
    logic [IDX_W-1:0] last_idx;
    logic             down_r;
    logic             cont_r;

    logic [IDX_W:0]   n_eff;
    logic [IDX_W:0]   n_eff_m1;
    logic [IDX_W-1:0] n_m1;
    logic [IDX_W-1:0] idx_inc;
    logic [IDX_W-1:0] idx_dec;
    logic             xfer;

    always_comb begin
        n_eff    = (count_in > N_MAX) ? N_MAX : count_in;
        n_eff_m1 = n_eff - {{IDX_W{1'b0}}, 1'b1};
        n_m1     = n_eff_m1[IDX_W-1:0];
        idx_inc  = out_idx + {{(IDX_W-1){1'b0}}, 1'b1};
        idx_dec  = out_idx - {{(IDX_W-1){1'b0}}, 1'b1};
        xfer     = out_valid & out_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last_idx  <= '0;
            down_r    <= 1'b0;
            cont_r    <= 1'b0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass_cnt  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        down_r   <= (mode == 2'd1);
                        cont_r   <= (mode == 2'd2);
                        last_idx <= n_m1;
                        pass_cnt <= '0;
                        busy     <= 1'b1;
                        if (n_eff == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= RUN;
                            out_valid <= 1'b1;
                            out_idx   <= (mode == 2'd1) ? n_m1 : '0;
                            out_last  <= (n_m1 == '0);
                        end
                    end
                end
                RUN: begin
                    if (xfer) begin
                        if (out_last) begin
                            if (pass_cnt != {PASS_W{1'b1}})
                                pass_cnt <= pass_cnt + {{(PASS_W-1){1'b0}}, 1'b1};
                            if (cont_r) begin
                                out_idx  <= '0;
                                out_last <= (last_idx == '0);
                            end else begin
                                state     <= DONE;
                                out_valid <= 1'b0;
                                out_last  <= 1'b0;
                                done      <= 1'b1;
                            end
                        end else if (down_r) begin
                            out_idx  <= idx_dec;
                            out_last <= (idx_dec == '0);
                        end else begin
                            out_idx  <= idx_inc;
                            out_last <= (idx_inc == last_idx);
                        end
                    end
                    // abort wins the state transition, but a same-cycle beat was still counted above
                    if (abort) begin
                        state     <= DONE;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
